// File: rtl/opb_reg_bank_pkg.sv
// Shared constants for the Simulink-to-PPC OPB register bank: word map, CTRL bit layout, channel limit.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package opb_reg_bank_pkg;

  // Upper bound on user data channels the word map is laid out for.
  localparam int unsigned MAX_NUM_CH = 16;

  // Byte offsets from the bank base address.
  localparam logic [31:0] OFF_CTRL    = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
  localparam logic [31:0] OFF_CH_BASE = 32'h0000_0008;

  // Same map expressed as word indices (byte offset / 4).
  localparam logic [31:0] WIDX_CTRL    = OFF_CTRL >> 2;
  localparam logic [31:0] WIDX_STATUS  = OFF_STATUS >> 2;
  localparam logic [31:0] WIDX_CH_BASE = OFF_CH_BASE >> 2;

  // CTRL bit positions, numbered LSB = 0 in user (little-endian) order.
  localparam int unsigned CTRL_FREEZE_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT    = 1;

  // Which register a decoded word address selects.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_CH,
    SEL_TSTAMP
  } word_sel_e;

  // TSTAMP sits directly after the last channel word.
  function automatic logic [31:0] tstamp_off(input int unsigned num_ch);
    return OFF_CH_BASE + 32'(4 * num_ch);
  endfunction

endpackage

// File: rtl/opb_reg_bank_slave_if.sv
// OPB slave front end: address decode, one-cycle ack with guard cycle, registered read mux, CTRL write strobe.
// Latency: ack and read data one cycle after a hit is sampled; CTRL write strobe valid during the ack cycle.
// Backpressure: none; back-to-back hits are acked every second cycle because of the ack guard.
module opb_reg_bank_slave_if
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_0800,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_08FF,
  parameter int          C_NUM_CH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:31]           opb_abus,
  input  logic                  opb_be3,
  input  logic [0:31]           opb_dbus,
  input  logic                  opb_rnw,
  input  logic                  opb_select,
  input  logic [31:0]           ctrl_word,
  input  logic [31:0]           status_word,
  input  logic [C_NUM_CH*32-1:0] ch_words,
  input  logic [31:0]           tstamp_word,
  output logic [0:31]           sl_dbus,
  output logic                  sl_xfer_ack,
  output logic                  ctrl_wr,
  output logic [31:0]           ctrl_wr_dat
);

  localparam logic [31:0] WIDX_TSTAMP = tstamp_off(C_NUM_CH) >> 2;

  logic [31:0] addr;
  logic [31:0] offset;
  logic [31:0] word_idx;
  logic        hit;
  logic        take;
  word_sel_e   word_sel;
  logic [3:0]  ch_idx;
  logic [31:0] rd_word;

  logic        ack_q;
  logic [31:0] rd_q;
  logic        wr_ctrl_q;
  logic [31:0] wr_dat_q;

  // OPB bit 0 is the MSB, so a plain assignment yields the numeric address.
  assign addr     = opb_abus;
  assign offset   = addr - C_BASEADDR;
  assign word_idx = offset >> 2;
  assign hit      = opb_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // A hit is only taken when no ack is pending; this enforces the idle cycle after every ack.
  assign take     = hit && !ack_q;

  // Decode the addressed word into a register selector and channel index.
  always_comb begin
    word_sel = SEL_NONE;
    ch_idx   = 4'd0;
    if (word_idx == WIDX_CTRL) begin
      word_sel = SEL_CTRL;
    end else if (word_idx == WIDX_STATUS) begin
      word_sel = SEL_STATUS;
    end else if (word_idx == WIDX_TSTAMP) begin
      word_sel = SEL_TSTAMP;
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (word_idx == WIDX_CH_BASE + 32'(i)) begin
          word_sel = SEL_CH;
          ch_idx   = 4'(i);
        end
      end
    end
  end

  // Read mux; unmapped in-range words read as zero.
  always_comb begin
    rd_word = 32'h0;
    case (word_sel)
      SEL_CTRL:   rd_word = ctrl_word;
      SEL_STATUS: rd_word = status_word;
      SEL_TSTAMP: rd_word = tstamp_word;
      SEL_CH: begin
        for (int i = 0; i < C_NUM_CH; i++) begin
          if (ch_idx == 4'(i)) rd_word = ch_words[i*32 +: 32];
        end
      end
      default:    rd_word = 32'h0;
    endcase
  end

  // Register ack, read data and the CTRL write request at the hit edge; data bus is zero outside the ack cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      rd_q      <= 32'h0;
      wr_ctrl_q <= 1'b0;
      wr_dat_q  <= 32'h0;
    end else begin
      ack_q <= take;
      if (take) begin
        rd_q      <= opb_rnw ? rd_word : 32'h0;
        wr_ctrl_q <= !opb_rnw && (word_sel == SEL_CTRL) && opb_be3;
        wr_dat_q  <= opb_dbus;
      end else begin
        rd_q      <= 32'h0;
        wr_ctrl_q <= 1'b0;
      end
    end
  end

  // Reset low aborts immediately: ack and data are suppressed even within the ack cycle itself.
  assign sl_xfer_ack = ack_q && rst_n;
  assign sl_dbus     = rst_n ? rd_q : 32'h0;
  // Bank applies the CTRL write at the edge that closes the ack cycle.
  assign ctrl_wr     = ack_q && wr_ctrl_q;
  assign ctrl_wr_dat = wr_dat_q;

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB register bank: CTRL/STATUS, per-channel capture registers with freeze, optional freeze timestamp (OPB_REG_BANK_TIMESTAMP_EN).
// Latency: OPB ack one cycle after the hit; channel capture and STATUS update on the valid edge.
// Backpressure: none; user_valid is never stalled, it is simply ignored while frozen.
module opb_register_bank_simulink2ppc
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0800,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_08FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CH     = 4,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                   OPB_Clk,
  input  logic                   OPB_Rst_n,
  input  logic [0:31]            OPB_ABus,
  input  logic [0:3]             OPB_BE,
  input  logic [0:31]            OPB_DBus,
  input  logic                   OPB_RNW,
  input  logic                   OPB_select,
  input  logic                   OPB_seqAddr,
  output logic [0:31]            Sl_DBus,
  output logic                   Sl_xferAck,
  output logic                   Sl_errAck,
  output logic                   Sl_retry,
  output logic                   Sl_toutSup,
  input  logic [C_NUM_CH*32-1:0] user_data_in,
  input  logic [C_NUM_CH-1:0]    user_valid,
  output logic                   frozen
);

  logic                   freeze_q;
  logic [31:0]            status_q;
  logic [C_NUM_CH*32-1:0] ch_q;
  logic [31:0]            tstamp_q;

  logic                   ctrl_wr;
  logic [31:0]            ctrl_wr_dat;
  logic [31:0]            ctrl_word;
  logic                   clr_pulse;
  logic                   freeze_rise;
  logic                   capture_en;
  logic                   unused_ok;

  // CLR is a write-only pulse, so only FREEZE is visible on read.
  assign ctrl_word   = {31'h0, freeze_q};
  assign clr_pulse   = ctrl_wr && ctrl_wr_dat[CTRL_CLR_BIT];
  assign freeze_rise = ctrl_wr && ctrl_wr_dat[CTRL_FREEZE_BIT] && !freeze_q;
  // Uses the pre-edge freeze state, so valid on the freeze-setting edge is still captured.
  assign capture_en  = !freeze_q;

  assign frozen      = freeze_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

  assign unused_ok   = &{1'b0, OPB_seqAddr, OPB_BE[0:2], ctrl_wr_dat[31:2]};

  opb_reg_bank_slave_if #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR),
    .C_NUM_CH   (C_NUM_CH)
  ) u_slave_if (
    .clk         (OPB_Clk),
    .rst_n       (OPB_Rst_n),
    .opb_abus    (OPB_ABus),
    .opb_be3     (OPB_BE[3]),
    .opb_dbus    (OPB_DBus),
    .opb_rnw     (OPB_RNW),
    .opb_select  (OPB_select),
    .ctrl_word   (ctrl_word),
    .status_word (status_q),
    .ch_words    (ch_q),
    .tstamp_word (tstamp_q),
    .sl_dbus     (Sl_DBus),
    .sl_xfer_ack (Sl_xferAck),
    .ctrl_wr     (ctrl_wr),
    .ctrl_wr_dat (ctrl_wr_dat)
  );

  // FREEZE is sticky until software writes it back to 0 with the low byte enabled.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      freeze_q <= 1'b0;
    end else if (ctrl_wr) begin
      freeze_q <= ctrl_wr_dat[CTRL_FREEZE_BIT];
    end
  end

  // Per-channel capture of user data while the bank is not frozen.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      ch_q <= '0;
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (capture_en && user_valid[i]) ch_q[i*32 +: 32] <= user_data_in[i*32 +: 32];
      end
    end
  end

  // Saturating update counter; a CLR write overrides a coincident increment.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      status_q <= 32'h0;
    end else if (clr_pulse) begin
      status_q <= 32'h0;
    end else if (capture_en && (|user_valid) && (status_q != 32'hFFFF_FFFF)) begin
      status_q <= status_q + 32'd1;
    end
  end

`ifdef OPB_REG_BANK_TIMESTAMP_EN
  logic [31:0] cyc_q;

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      cyc_q <= 32'h0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  // Snapshot the cycle count on each FREEZE 0->1 transition.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      tstamp_q <= 32'h0;
    end else if (freeze_rise) begin
      tstamp_q <= cyc_q;
    end
  end
`else
  logic unused_rise;
  assign unused_rise = freeze_rise;
  assign tstamp_q    = 32'h0;
`endif

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Self-checking bench for the OPB register bank: scoreboarded bus reads against a behavioural model.
// Latency: expects ack exactly one cycle after the hit edge.
// Backpressure: n/a (bench drives one transfer at a time).
module tb_opb_register_bank_simulink2ppc;

  localparam logic [31:0] BASE   = 32'h0100_0800;
  localparam logic [31:0] HIGH   = 32'h0100_08FF;
  localparam int          NCH    = 4;
  localparam logic [31:0] OFF_TS = 32'h8 + 32'(4 * NCH);

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic [0:31]       abus    = '0;
  logic [0:3]        be      = '0;
  logic [0:31]       dbus_w  = '0;
  logic              rnw     = 1'b0;
  logic              sel     = 1'b0;
  logic              seq     = 1'b0;
  logic [0:31]       sl_dbus;
  logic              xack, erra, retry, tout;
  logic [NCH*32-1:0] udat    = '0;
  logic [NCH-1:0]    uvld    = '0;
  logic              frozen;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];

  // behavioural model
  logic        m_freeze;
  logic [31:0] m_status;
  logic [31:0] m_ch[NCH];
  logic [31:0] m_tstamp;
  logic [31:0] m_cyc;

  opb_register_bank_simulink2ppc #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH),
    .C_NUM_CH   (NCH)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus_w),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seq),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (xack),
    .Sl_errAck    (erra),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout),
    .user_data_in (udat),
    .user_valid   (uvld),
    .frozen       (frozen)
  );

  always #5 clk = ~clk;

  // reference cycle counter
  always @(posedge clk) begin
    if (!rst_n) m_cyc <= 32'h0;
    else        m_cyc <= m_cyc + 32'd1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_read(input logic [31:0] off);
    logic [31:0] r;
    r = 32'h0;
    if (off == 32'h0) r = {31'h0, m_freeze};
    else if (off == 32'h4) r = m_status;
    else if (off == OFF_TS) r = m_tstamp;
    else begin
      for (int i = 0; i < NCH; i++) begin
        if (off == 32'h8 + 32'(4 * i)) r = m_ch[i];
      end
    end
    return r;
  endfunction

  task automatic model_valid(input logic [NCH-1:0] av, input logic [31:0] dat);
    if (!m_freeze && av != '0) begin
      for (int i = 0; i < NCH; i++) begin
        if (av[i]) m_ch[i] = dat;
      end
      if (m_status != 32'hFFFF_FFFF) m_status = m_status + 32'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sel = 1'b0;
    uvld = '0;
    repeat (3) @(negedge clk);
    m_freeze = 1'b0;
    m_status = 32'h0;
    m_tstamp = 32'h0;
    for (int i = 0; i < NCH; i++) m_ch[i] = 32'h0;
    rst_n = 1'b1;
  endtask

  task automatic pulse_valid(input logic [NCH-1:0] av, input logic [31:0] dat);
    @(negedge clk);
    uvld = av;
    for (int i = 0; i < NCH; i++) begin
      if (av[i]) udat[i*32 +: 32] = dat;
    end
    model_valid(av, dat);
    @(negedge clk);
    uvld = '0;
  endtask

  // One OPB transfer; av/adat are driven as user_valid during the ack cycle so they meet the ack edge.
  task automatic opb_xfer(input string nm, input logic [31:0] off, input logic rd,
                          input logic [3:0] be_v, input logic [31:0] wdat,
                          input logic [NCH-1:0] av, input logic [31:0] adat);
    logic [31:0] exp_v;
    int lat;
    @(negedge clk);
    abus = BASE + off;
    be = be_v;
    rnw = rd;
    dbus_w = rd ? 32'h0 : wdat;
    sel = 1'b1;
    if (rd) exp_q.push_back(model_read(off));
    lat = 0;
    while (lat < 8 && xack !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != 1) begin
      n_bad++;
      $display("FAIL %s ack_latency: got %0d cycles, expected 1", nm, lat);
    end
    if (rd) begin
      exp_v = exp_q.pop_front();
      if (xack === 1'b1) begin
        n_cmp++;
        if (sl_dbus !== exp_v) begin
          n_bad++;
          $display("FAIL %s rdata: got %h, expected %h", nm, sl_dbus, exp_v);
        end
      end
    end
    sel = 1'b0;
    rnw = 1'b0;
    abus = '0;
    be = '0;
    dbus_w = '0;
    uvld = av;
    for (int i = 0; i < NCH; i++) begin
      if (av[i]) udat[i*32 +: 32] = adat;
    end
    model_valid(av, adat);
    if (!rd && off == 32'h0 && be_v[0]) begin
      if (wdat[1]) m_status = 32'h0;
`ifdef OPB_REG_BANK_TIMESTAMP_EN
      if (wdat[0] && !m_freeze) m_tstamp = m_cyc;
`endif
      m_freeze = wdat[0];
    end
    @(negedge clk);
    uvld = '0;
    n_cmp++;
    if (xack !== 1'b0 || sl_dbus !== 32'h0) begin
      n_bad++;
      $display("FAIL %s post_ack_idle: got ack=%b dbus=%h, expected ack=0 dbus=0", nm, xack, sl_dbus);
    end
  endtask

  task automatic no_ack_window(input string nm, input logic [31:0] addr, input logic sel_v);
    int acks;
    @(negedge clk);
    abus = addr;
    rnw = 1'b1;
    sel = sel_v;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (xack !== 1'b0) acks++;
    end
    sel = 1'b0;
    abus = '0;
    n_cmp++;
    if (acks != 0) begin
      n_bad++;
      $display("FAIL %s no_ack: got %0d acks, expected 0", nm, acks);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({xack, erra, retry, tout, frozen} !== 5'b0 || sl_dbus !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack/err/retry/tout/frozen=%b dbus=%h, expected 0", {xack, erra, retry, tout, frozen}, sl_dbus);
    end
    opb_xfer("rst_ctrl",   32'h0,  1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("rst_status", 32'h4,  1'b1, 4'hF, 32'h0, '0, 32'h0);
    for (int i = 0; i < NCH; i++) opb_xfer("rst_ch", 32'h8 + 32'(4 * i), 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("rst_tstamp", OFF_TS, 1'b1, 4'hF, 32'h0, '0, 32'h0);
  endtask

  task automatic test_capture();
    pulse_valid(4'b0100, 32'hDEAD_BEEF);
    opb_xfer("cap_ch2",    32'h10, 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("cap_status", 32'h4,  1'b1, 4'hF, 32'h0, '0, 32'h0);
    pulse_valid(4'b1011, 32'hA5C3_0F96);
    opb_xfer("cap_ch0",    32'h8,  1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("cap_ch2b",   32'h10, 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("cap_ch3",    32'h14, 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("cap_status2", 32'h4, 1'b1, 4'hF, 32'h0, '0, 32'h0);
  endtask

  task automatic test_freeze();
    opb_xfer("frz_wr", 32'h0, 1'b0, 4'b1111, 32'h1, 4'b0001, 32'h11);
    n_cmp++;
    if (frozen !== 1'b1) begin
      n_bad++;
      $display("FAIL frz_frozen: got %b, expected 1", frozen);
    end
    pulse_valid(4'b0001, 32'h22);
    opb_xfer("frz_ch0",    32'h8,  1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("frz_status", 32'h4,  1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("frz_ctrl",   32'h0,  1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("frz_tstamp", OFF_TS, 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("frz_clear",  32'h0,  1'b0, 4'b1111, 32'h0, '0, 32'h0);
    n_cmp++;
    if (frozen !== 1'b0) begin
      n_bad++;
      $display("FAIL frz_unfrozen: got %b, expected 0", frozen);
    end
  endtask

  task automatic test_byte_enable();
    opb_xfer("be_wr", 32'h0, 1'b0, 4'b1110, 32'h1, '0, 32'h0);
    n_cmp++;
    if (frozen !== 1'b0) begin
      n_bad++;
      $display("FAIL be_frozen: got %b, expected 0", frozen);
    end
    opb_xfer("be_ctrl", 32'h0, 1'b1, 4'hF, 32'h0, '0, 32'h0);
  endtask

  task automatic test_decode();
    opb_xfer("dec_gap",   OFF_TS + 32'h4, 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("dec_last",  32'hFC,         1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("dec_ro_wr", 32'h4,          1'b0, 4'hF, 32'h1234_5678, '0, 32'h0);
    opb_xfer("dec_ro_rd", 32'h4,          1'b1, 4'hF, 32'h0, '0, 32'h0);
    no_ack_window("dec_above", HIGH + 32'h1, 1'b1);
    no_ack_window("dec_below", BASE - 32'h4, 1'b1);
    no_ack_window("dec_nosel", BASE + 32'h4, 1'b0);
  endtask

  task automatic test_timestamp();
    int guard;
    do_reset();
    guard = 0;
    while (m_cyc != 32'd98 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    opb_xfer("ts_freeze", 32'h0,  1'b0, 4'hF, 32'h1, '0, 32'h0);
    opb_xfer("ts_read",   OFF_TS, 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("ts_unfrz",  32'h0,  1'b0, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("ts_hold",   OFF_TS, 1'b1, 4'hF, 32'h0, '0, 32'h0);
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.status_q = 32'hFFFF_FFFE;
    #1;
    release dut.status_q;
    m_status = 32'hFFFF_FFFE;
    repeat (3) pulse_valid(4'b0010, 32'h5555_0001);
    opb_xfer("sat_status", 32'h4, 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("sat_clr",    32'h0, 1'b0, 4'hF, 32'h2, 4'b0001, 32'h33);
    opb_xfer("sat_zero",   32'h4, 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("sat_ctrl",   32'h0, 1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("sat_ch0",    32'h8, 1'b1, 4'hF, 32'h0, '0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int acks;
    logic mid;
    @(negedge clk);
    abus = BASE;
    rnw = 1'b1;
    be = 4'hF;
    sel = 1'b1;
    acks = 0;
    mid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (xack === 1'b1) acks++;
      if (k == 2) mid = xack;
      if (k == 4) sel = 1'b0;
    end
    abus = '0;
    n_cmp++;
    if (acks != 2 || mid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_acks: got %0d acks (gap cycle ack=%b), expected 2 acks with gap", acks, mid);
    end
  endtask

  task automatic test_reset_abort();
    opb_xfer("abort_frz", 32'h0, 1'b0, 4'hF, 32'h1, '0, 32'h0);
    @(negedge clk);
    abus = BASE + 32'h4;
    rnw = 1'b1;
    sel = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (xack !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre_ack: got %b, expected 1", xack);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (xack !== 1'b0 || sl_dbus !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_same_cycle: got ack=%b dbus=%h, expected 0/0", xack, sl_dbus);
    end
    @(negedge clk);
    n_cmp++;
    if (xack !== 1'b0 || sl_dbus !== 32'h0 || frozen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_next_cycle: got ack=%b dbus=%h frozen=%b, expected 0/0/0", xack, sl_dbus, frozen);
    end
    sel = 1'b0;
    abus = '0;
    @(negedge clk);
    m_freeze = 1'b0;
    m_status = 32'h0;
    m_tstamp = 32'h0;
    for (int i = 0; i < NCH; i++) m_ch[i] = 32'h0;
    rst_n = 1'b1;
    opb_xfer("abort_ctrl",   32'h0,  1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("abort_status", 32'h4,  1'b1, 4'hF, 32'h0, '0, 32'h0);
    opb_xfer("abort_ch2",    32'h10, 1'b1, 4'hF, 32'h0, '0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_capture();
    test_freeze();
    test_byte_enable();
    test_decode();
    test_saturate();
    test_back_to_back();
    test_timestamp();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_simulink2ppc.md
OPB_REGISTER_BANK_SIMULINK2PPC -- requirements
Module: opb_register_bank_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01000800, base byte address of the bank.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010008FF, last decoded byte address.
REQ-003 SHALL have parameters C_OPB_AWIDTH=32 and C_OPB_DWIDTH=32, bus widths, fixed at 32.
REQ-004 SHALL have parameter C_NUM_CH, default 4, range 1..16, number of user data channels.
REQ-005 SHALL have parameter C_FAMILY, default "virtex5", informational only.
REQ-006 Ports: OPB_Clk  in  1  sole clock; all logic on rising edge.
REQ-007 Ports: OPB_Rst_n  in  1  reset, synchronous, active-low.
REQ-008 Ports: OPB_ABus in [0:31] address; OPB_BE in [0:3] byte enables; OPB_DBus in [0:31] write data; OPB_RNW in 1 (1=read); OPB_select in 1; OPB_seqAddr in 1 (ignored).
REQ-009 Ports: Sl_DBus out [0:31] read data; Sl_xferAck out 1; Sl_errAck, Sl_retry, Sl_toutSup out 1, constant 0.
REQ-010 Ports: user_data_in in [C_NUM_CH*32-1:0], channel i at bits [32i+31:32i]; user_valid in [C_NUM_CH-1:0], per-channel capture strobe; frozen out 1, current freeze state.

Function
REQ-011 Word map (offset from C_BASEADDR, bytes): 0x0 CTRL (R/W), 0x4 STATUS (RO), 0x8+4i CH[i] (RO), 0x8+4*C_NUM_CH TSTAMP (RO); other in-range words read 0.
REQ-012 Decode hit = OPB_select & C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
REQ-013 Sl_xferAck SHALL be 1 for exactly one cycle, the cycle after a hit is sampled, then 0 for at least one cycle (ack_q guard); back-to-back transfers ack every second cycle.
REQ-014 Sl_DBus SHALL be 0 except in the read-ack cycle, where it carries the addressed word (user bit 31 on OPB bit 0).
REQ-015 Writes SHALL take effect at the ack edge; CTRL updated only when OPB_BE[3]=1; writes to RO/unmapped words acked and ignored.
REQ-016 CTRL bit0 FREEZE (sticky, R/W); CTRL bit1 CLR (write-1 pulse, reads 0); other bits read 0.
REQ-017 When not frozen, CH[i] loads user_data_in channel i on each edge with user_valid[i]=1; when frozen all CH hold, user_valid ignored.
REQ-018 Valid coincident with the FREEZE-setting ack edge SHALL still be captured; freeze applies from the following edge.
REQ-019 STATUS = 32-bit update count: +1 on each unfrozen edge with any user_valid bit set; saturates at 0xFFFFFFFF; CLR zeroes it, CLR wins over coincident increment.
REQ-020 frozen SHALL equal CTRL.FREEZE with zero added latency from the register.
REQ-021 OPB_Rst_n low mid-transfer SHALL abort: no ack that cycle or next, state reset.

Reset
REQ-022 On OPB_Rst_n=0 at an edge: CTRL=0, STATUS=0, all CH=0, TSTAMP and cycle counter=0, ack_q=0, Sl_xferAck=0, Sl_DBus=0, frozen=0.

Configuration
REQ-023 Macro OPB_REG_BANK_TIMESTAMP_EN defined: free-running 32-bit cycle counter (wraps 0xFFFFFFFF->0) latched into TSTAMP on each FREEZE 0->1 transition.
REQ-024 Macro undefined: no counter logic; TSTAMP word reads 0.

Structure
REQ-025 Package opb_reg_bank_pkg SHALL hold word offsets (CTRL, STATUS, CH base), CTRL bit indices, max channel count.
REQ-026 Sub-module opb_reg_bank_slave_if SHALL contain address decode, ack generation and read mux registering; bank storage stays in top.

Verification
REQ-027 C_NUM_CH=4; valid[2]=1 with 0xDEADBEEF, read 0x10 -> Sl_DBus=0xDEADBEEF in the single ack cycle, STATUS=1.
REQ-028 Write CTRL=0x1 BE=1111 same edge as valid[0] data 0x11 -> CH0=0x11; later valid[0] data 0x22 -> CH0 stays 0x11, frozen=1.
REQ-029 Write CTRL=0x1 with BE=1110 -> CTRL unchanged, frozen=0, ack still given.
REQ-030 STATUS preloaded 0xFFFFFFFE, three valid edges -> 0xFFFFFFFF; CLR with coincident valid -> 0.
REQ-031 TIMESTAMP_EN: freeze at cycle 100 after reset -> TSTAMP=100; undefined -> TSTAMP=0.
REQ-032 OPB_select held 4 cycles -> exactly 2 acks; OPB_Rst_n low during hit -> no ack, all outputs 0.
